uc_multiciclo: RTL and testbench

- Multi-cycle control unit that drives the existing 64-bit datapath: PC, instruction memory, IR, RF, ULA, RAM and the three muxes.
- It receives `saida_IR` from the datapath and sequences fetch, decode, execute and writeback through a state machine.
- It generates every datapath control strobe and field that the datapath testbench currently drives by hand.
- Supported subset: ld, sd, add, sub, addi.

---
 rtl/uc_multiciclo.sv | 235 +++++++++++++++++++++++
 tb/tb_uc_multiciclo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit for the 64-bit datapath (PC, IMEM, IR, RF, ULA, RAM, muxes).
// Sequences fetch/decode/execute/writeback for ld, sd, add, sub, addi.
// Optional macro UC_ILLEGAL_TRAP_EN: illegal opcodes trap into a sticky halt state
// instead of retiring as NOPs.
module uc_multiciclo #(
    parameter int unsigned PC_RESET = 0,
    parameter int unsigned PC_MAX   = 31
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic [31:0] saida_IR,
    output logic        load_PC,
    output logic [63:0] PCres,
    output logic        load_IR,
    output logic [4:0]  Ra,
    output logic [4:0]  Rb,
    output logic [4:0]  Rw,
    output logic        we,
    output logic        we_ram,
    output logic        we_mi,
    output logic [63:0] entrada_mux_add_sub,
    output logic        decisor0,
    output logic        decisor1,
    output logic        decisor2,
    output logic        somador_subtrator,
    output logic        instr_done,
    output logic        illegal,
    output logic [2:0]  estado
);

    localparam int unsigned PcW = (PC_MAX < 1) ? 1 : $clog2(PC_MAX + 1);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StImem   = 3'd1,
        StIr     = 3'd2,
        StDecode = 3'd3,
        StExec   = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    typedef enum logic [2:0] {ClsNop, ClsLd, ClsSd, ClsR, ClsI} cls_e;

    state_e         state_q, state_d;
    logic [PcW-1:0] pc_q, pc_d;
    logic [4:0]     rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [63:0]    imm_q, imm_d;
    logic           sub_q, sub_d;
    cls_e           cls_q, cls_d;
`ifdef UC_ILLEGAL_TRAP_EN
    logic           illegal_q, illegal_d;
`endif

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    cls_e        cls_dec;
    logic [63:0] imm_dec;
    logic        retire;

    assign opcode = saida_IR[6:0];
    assign funct3 = saida_IR[14:12];
    assign funct7 = saida_IR[31:25];

    // Classify the instruction held in IR; anything outside the subset is ClsNop.
    always_comb begin
        cls_dec = ClsNop;
        if (opcode == 7'b0000011 && funct3 == 3'b011) begin
            cls_dec = ClsLd;
        end else if (opcode == 7'b0100011 && funct3 == 3'b011) begin
            cls_dec = ClsSd;
        end else if (opcode == 7'b0110011 && funct3 == 3'b000 &&
                     (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
            cls_dec = ClsR;
        end else if (opcode == 7'b0010011 && funct3 == 3'b000) begin
            cls_dec = ClsI;
        end
        imm_dec = (cls_dec == ClsSd) ?
                  {{52{saida_IR[31]}}, saida_IR[31:25], saida_IR[11:7]} :
                  {{52{saida_IR[31]}}, saida_IR[31:20]};
    end

    // Loads retire from WB; everything else that reaches EXEC retires there.
    assign retire = (state_q == StExec && cls_q != ClsLd) || (state_q == StWb);

    // Next-state, decode capture and PC advance.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        sub_d   = sub_q;
        cls_d   = cls_q;
`ifdef UC_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            StFetch:  if (run) state_d = StImem;
            StImem:   state_d = StIr;
            StIr:     state_d = StDecode;
            StDecode: begin
                rd_d    = saida_IR[11:7];
                rs1_d   = saida_IR[19:15];
                rs2_d   = saida_IR[24:20];
                imm_d   = imm_dec;
                sub_d   = saida_IR[30];
                cls_d   = cls_dec;
                state_d = StExec;
`ifdef UC_ILLEGAL_TRAP_EN
                if (cls_dec == ClsNop) begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end
`endif
            end
            StExec:   state_d = (cls_q == ClsLd) ? StWb : StFetch;
            StWb:     state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
        if (retire) begin
            pc_d = (pc_q == PcW'(PC_MAX)) ? '0 : pc_q + PcW'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StFetch;
            pc_q    <= PcW'(PC_RESET);
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            sub_q   <= 1'b0;
            cls_q   <= ClsNop;
`ifdef UC_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            sub_q   <= sub_d;
            cls_q   <= cls_d;
`ifdef UC_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Datapath controls from the current state and decoded fields.
    always_comb begin
        load_PC             = 1'b0;
        PCres               = '0;
        load_IR             = 1'b0;
        Ra                  = '0;
        Rb                  = '0;
        Rw                  = '0;
        we                  = 1'b0;
        we_ram              = 1'b0;
        entrada_mux_add_sub = '0;
        decisor0            = 1'b0;
        decisor1            = 1'b0;
        decisor2            = 1'b0;
        somador_subtrator   = 1'b0;
        case (state_q)
            StFetch: if (run) begin
                load_PC = 1'b1;
                PCres   = {{(64-PcW){1'b0}}, pc_q};
            end
            StIr: load_IR = 1'b1;
            StExec: case (cls_q)
                ClsR: begin
                    Ra = rs1_q; Rb = rs2_q; Rw = rd_q;
                    decisor1          = 1'b1;
                    somador_subtrator = sub_q;
                    we                = (rd_q != 5'd0);
                end
                ClsI: begin
                    Ra = rs1_q; Rw = rd_q;
                    entrada_mux_add_sub = imm_q;
                    decisor0 = 1'b1;
                    decisor1 = 1'b1;
                    we       = (rd_q != 5'd0);
                end
                ClsLd: begin
                    Ra = rs1_q; Rw = rd_q;
                    entrada_mux_add_sub = imm_q;
                    decisor0 = 1'b1;
                    decisor1 = 1'b1;
                    decisor2 = 1'b1;
                end
                ClsSd: begin
                    // Data comes out of port A, base address out of port B.
                    Ra = rs2_q; Rb = rs1_q;
                    entrada_mux_add_sub = imm_q;
                    decisor0 = 1'b1;
                    we_ram   = 1'b1;
                end
                default: ;
            endcase
            StWb: begin
                Ra = rs1_q; Rw = rd_q;
                entrada_mux_add_sub = imm_q;
                decisor2 = 1'b1;
                we       = (rd_q != 5'd0);
            end
            default: ;
        endcase
        // No write of any kind may happen on a reset edge.
        if (!reset_n) begin
            load_PC = 1'b0;
            load_IR = 1'b0;
            we      = 1'b0;
            we_ram  = 1'b0;
        end
    end

    assign instr_done = retire & reset_n;
    assign we_mi      = 1'b0;
    assign estado     = state_q;
`ifdef UC_ILLEGAL_TRAP_EN
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo: walks instructions through the FSM and checks
// the control strobes against hand-computed values.
module tb_uc_multiciclo;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic [31:0] saida_IR;
    logic        load_PC, load_IR, we, we_ram, we_mi;
    logic [63:0] PCres, entrada_mux_add_sub;
    logic [4:0]  Ra, Rb, Rw;
    logic        decisor0, decisor1, decisor2, somador_subtrator;
    logic        instr_done, illegal;
    logic [2:0]  estado;

    int n_vec = 0;
    int n_err = 0;
    int exp_pc = 0;

    uc_multiciclo #(.PC_RESET(0), .PC_MAX(31)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .run                 (run),
        .saida_IR            (saida_IR),
        .load_PC             (load_PC),
        .PCres               (PCres),
        .load_IR             (load_IR),
        .Ra                  (Ra),
        .Rb                  (Rb),
        .Rw                  (Rw),
        .we                  (we),
        .we_ram              (we_ram),
        .we_mi               (we_mi),
        .entrada_mux_add_sub (entrada_mux_add_sub),
        .decisor0            (decisor0),
        .decisor1            (decisor1),
        .decisor2            (decisor2),
        .somador_subtrator   (somador_subtrator),
        .instr_done          (instr_done),
        .illegal             (illegal),
        .estado              (estado)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int next_pc(input int pc);
        return (pc == 31) ? 0 : pc + 1;
    endfunction

    // From FETCH up to DECODE, presenting ir in IR once load_IR has fired.
    task automatic to_decode(input logic [31:0] ir);
        check_val("fetch_estado", estado, 0);
        check_val("fetch_load_PC", load_PC, 1);
        check_val("fetch_PCres", PCres, exp_pc);
        tick();
        check_val("imem_estado", estado, 1);
        tick();
        check_val("ir_estado", estado, 2);
        check_val("ir_load_IR", load_IR, 1);
        saida_IR = ir;
        tick();
        check_val("dec_estado", estado, 3);
        check_val("dec_we", we, 0);
        tick();
    endtask

    task automatic to_exec(input logic [31:0] ir);
        to_decode(ir);
        check_val("exec_estado", estado, 4);
    endtask

    initial begin
        reset_n  = 1'b0;
        run      = 1'b1;
        saida_IR = 32'h0;
        #1;
        check_val("rst_load_PC_gated", load_PC, 0);
        tick();
        tick();
        check_val("rst_estado", estado, 0);
        check_val("rst_illegal", illegal, 0);
        check_val("rst_we_mi", we_mi, 0);

        // run=0 holds FETCH with no PC load
        reset_n = 1'b1;
        run     = 1'b0;
        #1;
        check_val("hold_load_PC", load_PC, 0);
        tick();
        tick();
        check_val("hold_estado", estado, 0);
        check_val("hold_load_PC2", load_PC, 0);
        run = 1'b1;
        #1;

        // addi x1,x2,9
        to_exec(32'h00910093);
        check_val("addi_Ra", Ra, 2);
        check_val("addi_Rw", Rw, 1);
        check_val("addi_imm", entrada_mux_add_sub, 9);
        check_val("addi_d0", decisor0, 1);
        check_val("addi_d1", decisor1, 1);
        check_val("addi_d2", decisor2, 0);
        check_val("addi_we", we, 1);
        check_val("addi_done", instr_done, 1);
        tick();
        exp_pc = next_pc(exp_pc);

        // ld x2,0(x0): 6 cycles, write in WB
        to_exec(32'h00003103);
        check_val("ld_Ra", Ra, 0);
        check_val("ld_d2", decisor2, 1);
        check_val("ld_we", we, 0);
        check_val("ld_exec_done", instr_done, 0);
        tick();
        check_val("ld_wb_estado", estado, 5);
        check_val("ld_wb_we", we, 1);
        check_val("ld_wb_Rw", Rw, 2);
        check_val("ld_wb_d2", decisor2, 1);
        check_val("ld_wb_done", instr_done, 1);
        tick();
        exp_pc = next_pc(exp_pc);

        // sub x7,x6,x3
        to_exec(32'h403303B3);
        check_val("sub_Ra", Ra, 6);
        check_val("sub_Rb", Rb, 3);
        check_val("sub_Rw", Rw, 7);
        check_val("sub_ss", somador_subtrator, 1);
        check_val("sub_d0", decisor0, 0);
        check_val("sub_d1", decisor1, 1);
        check_val("sub_we", we, 1);
        tick();
        exp_pc = next_pc(exp_pc);

        // sd x7,8(x2)
        to_exec(32'h00713423);
        check_val("sd_Ra", Ra, 7);
        check_val("sd_Rb", Rb, 2);
        check_val("sd_imm", entrada_mux_add_sub, 8);
        check_val("sd_d0", decisor0, 1);
        check_val("sd_d1", decisor1, 0);
        check_val("sd_we_ram", we_ram, 1);
        check_val("sd_we", we, 0);
        check_val("sd_done", instr_done, 1);
        tick();
        exp_pc = next_pc(exp_pc);

        // addi x1,x2,-1: sign-extended immediate
        to_exec(32'hFFF10093);
        check_val("neg_imm", entrada_mux_add_sub, 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("neg_we", we, 1);
        tick();
        exp_pc = next_pc(exp_pc);

        // addi x0,x0,5: write to x0 suppressed
        to_exec(32'h00500013);
        check_val("x0_imm", entrada_mux_add_sub, 5);
        check_val("x0_we", we, 0);
        check_val("x0_done", instr_done, 1);
        tick();
        exp_pc = next_pc(exp_pc);

        // add x1,x2,x3
        to_exec(32'h003100B3);
        check_val("add_Rb", Rb, 3);
        check_val("add_ss", somador_subtrator, 0);
        check_val("add_we", we, 1);
        tick();
        exp_pc = next_pc(exp_pc);

        // Run addi up to PC_MAX and check the wrap
        while (exp_pc != 0) begin
            to_exec(32'h00110093);
            check_val("loop_done", instr_done, 1);
            tick();
            exp_pc = next_pc(exp_pc);
        end
        check_val("wrap_PCres", PCres, 0);

        // Reset during EXEC of an addi
        to_exec(32'h00910093);
        reset_n = 1'b0;
        #1;
        check_val("rst_exec_we", we, 0);
        tick();
        reset_n = 1'b1;
        #1;
        check_val("rst_exec_estado", estado, 0);
        check_val("rst_exec_PCres", PCres, 0);
        exp_pc = 0;

        // Illegal opcode
        to_decode(32'hFFFFFFFF);
`ifdef UC_ILLEGAL_TRAP_EN
        check_val("ill_estado", estado, 6);
        check_val("ill_flag", illegal, 1);
        check_val("ill_done", instr_done, 0);
        tick();
        tick();
        check_val("ill_hold_estado", estado, 6);
        check_val("ill_hold_flag", illegal, 1);
        check_val("ill_hold_load_PC", load_PC, 0);
`else
        check_val("nop_estado", estado, 4);
        check_val("nop_we", we, 0);
        check_val("nop_we_ram", we_ram, 0);
        check_val("nop_done", instr_done, 1);
        check_val("nop_illegal", illegal, 0);
        tick();
        check_val("nop_next_estado", estado, 0);
        check_val("nop_next_PCres", PCres, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
